rr_req_client: RTL and testbench
================================

// Module: rr_req_client
// PURPOSE
//  Requester-side companion to the 4-way round-robin arbiter (rrarb).
//  - Buffers transactions from NUM_CLIENTS independent producers in per-client FIFOs.
//  - Drives the arbiter's request vector from FIFO occupancy.
//  - Consumes the arbiter's one-hot grant: pops the granted FIFO and emits its head
//    word on a shared output channel, tagged with the source index.
// PARAMETERS
//  NUM_CLIENTS  4  number of producers; req/gnt vector width
//  DATA_W       8  payload width per transaction
//  DEPTH        4  entries per client FIFO; power of 2, >= 2
// PORTS
//  clk          in   1                   rising-edge clock
//  reset        in   1                   asynchronous, active-high
//  in_valid_i   in   NUM_CLIENTS         per-client push strobe
//  in_data_i    in   NUM_CLIENTS*DATA_W  client k payload at [k*DATA_W +: DATA_W]
//  in_ready_o   out  NUM_CLIENTS         per-client FIFO not full
//  req_o        out  NUM_CLIENTS         to arbiter req_i; bit k = FIFO k non-empty
//  gnt_i        in   NUM_CLIENTS         from arbiter gnt_o; expected one-hot or zero
//  out_valid_o  out  1                   one-cycle pulse: a granted word is on out_*
//  out_data_o   out  DATA_W              granted payload
//  out_src_o    out  $clog2(NUM_CLIENTS) index of the client that supplied out_data_o
//  err_o        out  1                   sticky: gnt_i seen with more than one bit set
// BEHAVIOUR
//  Reset (async assert; deassert synchronous to clk):
//  - All FIFOs empty; pointers/counts 0.
//  - in_ready_o = all 1s; req_o = 0; out_valid_o = 0; out_data_o = 0; out_src_o = 0;
//    err_o = 0.
//  - Reset mid-operation discards all buffered data immediately.
//  FIFO k:
//  - Push when in_valid_i[k] && in_ready_o[k] at a clk edge.
//  - in_ready_o[k] = (count_k != DEPTH); combinational from state only, not from gnt_i.
//  - A full FIFO refuses a push even if it is popped in the same cycle.
//  - Pointers wrap modulo DEPTH; count width is $clog2(DEPTH)+1.
//  Request:
//  - req_o[k] = (count_k != 0); combinational from registered state.
//  - A push into an empty FIFO raises req_o[k] the cycle after the push edge.
//  Grant / pop:
//  - gnt_i is sampled at the clk edge.
//  - If gnt_i is one-hot at bit k and count_k != 0:
//    - pop FIFO k;
//    - next cycle out_valid_o = 1, out_data_o = old head of FIFO k, out_src_o = k.
//    - Latency is exactly 1 cycle from the grant edge to valid output.
//  - If gnt_i is one-hot at an empty client: ignored, no pop, out_valid_o = 0, no error.
//    This covers grant lag after a FIFO drains.
//  - If gnt_i is zero: no pop, out_valid_o = 0.
//  - If gnt_i has 2 or more bits set: no pop, out_valid_o = 0; err_o sets and holds
//    until reset.
//  - out_data_o / out_src_o hold their last values while out_valid_o = 0.
//  - There is no output backpressure; the consumer must accept every pulse.
//  Simultaneous push + pop on the same non-full FIFO:
//  - Both take effect and count is unchanged.
//  - If the FIFO held 1 entry, the popped word is the old head, the new word becomes
//    head, and req_o[k] stays 1.
//  - A push into an empty FIFO in the same cycle as its grant is not popped (req was 0).
//  Back-to-back grants to the same client:
//  - Pop one word per cycle; out_valid_o stays high on consecutive cycles.
// TESTING
//  1. Reset with in_valid_i = 0 -> req_o = 0000, in_ready_o = 1111, out_valid_o = 0,
//     err_o = 0.
//  2. Push 8'hA1 to client 1 and 8'hB3 to client 3 with the real rrarb connected
//     -> req_o = 1010. Each word appears exactly once with out_src_o = 1 and 3, in the
//     arbiter's grant order, then req_o = 0000.
//  3. Push 4 words (8'h10..8'h13) to client 0 with no grant -> in_ready_o[0] = 0; a 5th
//     push is dropped. Then gnt_i = 0001 for 4 cycles -> out_data_o = 10, 11, 12, 13 on
//     consecutive cycles, then in_ready_o[0] = 1.
//  4. gnt_i = 0100 while FIFO 2 is empty -> out_valid_o = 0, err_o = 0, all counts
//     unchanged.
//  5. gnt_i = 0011 with FIFOs 0 and 1 non-empty -> no pop, out_valid_o = 0, err_o = 1;
//     err_o stays 1 until reset.
//  6. Load 2 words into each FIFO, assert reset for 1 cycle mid-stream -> req_o = 0000
//     and out_valid_o = 0 immediately (asynchronous); no stale word is emitted after
//     deassert.

Source files
------------

// File: rtl/rr_req_client.sv
// Requester-side companion to a round-robin arbiter: per-client FIFOs drive req_o,
// and a one-hot grant pops the granted FIFO onto a shared, source-tagged output.
module rr_req_client #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        in_valid_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] in_data_i,
  output logic [NUM_CLIENTS-1:0]        in_ready_o,
  output logic [NUM_CLIENTS-1:0]        req_o,
  input  logic [NUM_CLIENTS-1:0]        gnt_i,
  output logic                          out_valid_o,
  output logic [DATA_W-1:0]             out_data_o,
  output logic [$clog2(NUM_CLIENTS)-1:0] out_src_o,
  output logic                          err_o
);

  localparam int SRC_W = $clog2(NUM_CLIENTS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic                               gnt_one_hot;
  logic                               gnt_multi;
  logic [NUM_CLIENTS-1:0]             push;
  logic [NUM_CLIENTS-1:0]             pop;
  logic [NUM_CLIENTS-1:0][DATA_W-1:0] head;
  logic [SRC_W-1:0]                   pop_idx;
  logic [DATA_W-1:0]                  pop_data;

  assign gnt_one_hot = (gnt_i != '0) && ((gnt_i & (gnt_i - 1'b1)) == '0);
  assign gnt_multi   = (gnt_i != '0) && !gnt_one_hot;

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_client
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Fullness is judged on registered state only, so a pop never frees a slot early.
    assign in_ready_o[k] = (count != FULL_CNT);
    assign req_o[k]      = (count != '0);
    assign push[k]       = in_valid_i[k] && in_ready_o[k];
    assign pop[k]        = gnt_one_hot && gnt_i[k] && (count != '0);
    assign head[k]       = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push[k]) begin
        mem[wr_ptr] <= in_data_i[k*DATA_W +: DATA_W];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[k]) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop[k]) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push[k], pop[k]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    pop_idx  = '0;
    pop_data = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (pop[k]) begin
        pop_idx  = SRC_W'(k);
        pop_data = head[k];
      end
    end
  end

  // Output word/source hold their last values between pulses; err_o is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      out_valid_o <= |pop;
      if (|pop) begin
        out_data_o <= pop_data;
        out_src_o  <= pop_idx;
      end
      if (gnt_multi) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_req_client.sv
// Self-checking bench for rr_req_client: queue-based reference model, directed
// scenarios plus a randomized phase with a round-robin grant source.
module tb_rr_req_client;

  localparam int NC    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     in_valid_i;
  logic [NC*DW-1:0]  in_data_i;
  logic [NC-1:0]     in_ready_o;
  logic [NC-1:0]     req_o;
  logic [NC-1:0]     gnt_i;
  logic              out_valid_o;
  logic [DW-1:0]     out_data_o;
  logic [1:0]        out_src_o;
  logic              err_o;

  rr_req_client #(.NUM_CLIENTS(NC), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_src_o   (out_src_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: one queue per client plus the expected output registers.
  logic [DW-1:0] q [NC][$];
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [1:0]    exp_src;
  logic          exp_err;
  int            rr_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] model_req();
    logic [NC-1:0] r;
    for (int k = 0; k < NC; k++) r[k] = (q[k].size() != 0);
    return r;
  endfunction

  function automatic logic [NC-1:0] model_ready();
    logic [NC-1:0] r;
    for (int k = 0; k < NC; k++) r[k] = (q[k].size() < DEPTH);
    return r;
  endfunction

  function automatic logic model_empty();
    return model_req() == '0;
  endfunction

  // Round-robin grant computed from the model's occupancy, searching after the last winner.
  function automatic logic [NC-1:0] rr_grant();
    logic [NC-1:0] g;
    int idx;
    g = '0;
    for (int i = 1; i <= NC; i++) begin
      idx = (rr_last + i) % NC;
      if (g == '0 && q[idx].size() != 0) begin
        g[idx]  = 1'b1;
        rr_last = idx;
      end
    end
    return g;
  endfunction

  function automatic logic [NC*DW-1:0] one_word(input int k, input logic [DW-1:0] w);
    logic [NC*DW-1:0] d;
    d = '0;
    d[k*DW +: DW] = w;
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) q[k].delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_src   = '0;
    exp_err   = 1'b0;
    rr_last   = NC - 1;
  endtask

  task automatic checkOutput();
    check("out_valid", 32'(out_valid_o), 32'(exp_valid));
    check("out_data",  32'(out_data_o),  32'(exp_data));
    check("out_src",   32'(out_src_o),   32'(exp_src));
    check("err",       32'(err_o),       32'(exp_err));
  endtask

  // Called at a negedge: drive inputs, check combinational outputs, advance one cycle.
  task automatic applyStimulus(input logic [NC-1:0] v, input logic [NC*DW-1:0] d,
                               input logic [NC-1:0] g);
    int sz [NC];
    in_valid_i = v;
    in_data_i  = d;
    gnt_i      = g;
    #1;
    check("req",   32'(req_o),      32'(model_req()));
    check("ready", 32'(in_ready_o), 32'(model_ready()));
    for (int k = 0; k < NC; k++) sz[k] = q[k].size();
    exp_valid = 1'b0;
    if ($countones(g) == 1) begin
      for (int k = 0; k < NC; k++) begin
        if (g[k] && sz[k] != 0) begin
          exp_data  = q[k].pop_front();
          exp_src   = 2'(k);
          exp_valid = 1'b1;
        end
      end
    end else if ($countones(g) > 1) begin
      exp_err = 1'b1;
    end
    for (int k = 0; k < NC; k++) begin
      if (v[k] && sz[k] < DEPTH) q[k].push_back(d[k*DW +: DW]);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [NC-1:0]    v;
    logic [NC*DW-1:0] d;
    logic [NC-1:0]    g;
    int               guard;

    // 1. Reset state
    reset      = 1'b1;
    in_valid_i = '0;
    in_data_i  = '0;
    gnt_i      = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_req",   32'(req_o),       32'h0);
    check("rst_ready", 32'(in_ready_o),  32'hF);
    check("rst_valid", 32'(out_valid_o), 32'h0);
    check("rst_err",   32'(err_o),       32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 2. One word each to clients 1 and 3, drained in round-robin order
    applyStimulus(4'b1010, one_word(1, 8'hA1) | one_word(3, 8'hB3), 4'b0000);
    check("t2_req", 32'(req_o), 32'hA);
    applyStimulus('0, '0, rr_grant());
    check("t2_src_a",  32'(out_src_o),  32'd1);
    check("t2_data_a", 32'(out_data_o), 32'hA1);
    applyStimulus('0, '0, rr_grant());
    check("t2_src_b",  32'(out_src_o),  32'd3);
    check("t2_data_b", 32'(out_data_o), 32'hB3);
    applyStimulus('0, '0, '0);
    check("t2_req_empty", 32'(req_o), 32'h0);

    // 3. Fill client 0, fifth push refused, then four back-to-back grants
    for (int i = 0; i < 5; i++) applyStimulus(4'b0001, one_word(0, 8'(8'h10 + i)), '0);
    check("t3_full", 32'(in_ready_o[0]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus('0, '0, 4'b0001);
      check("t3_valid", 32'(out_valid_o), 32'h1);
      check("t3_data",  32'(out_data_o),  32'(8'h10 + i));
    end
    check("t3_ready_back", 32'(in_ready_o[0]), 32'h1);
    applyStimulus('0, '0, 4'b0001);
    check("t3_lag_grant", 32'(out_valid_o), 32'h0);

    // 4. Grant to an empty client is ignored
    applyStimulus(4'b0001, one_word(0, 8'h55), '0);
    applyStimulus('0, '0, 4'b0100);
    check("t4_valid", 32'(out_valid_o), 32'h0);
    check("t4_err",   32'(err_o),       32'h0);
    check("t4_req",   32'(req_o),       32'h1);
    applyStimulus('0, '0, 4'b0001);
    check("t4_data",  32'(out_data_o),  32'h55);

    // Randomized traffic with legal grants, including same-cycle push/pop
    for (int n = 0; n < 400; n++) begin
      v = 4'($urandom_range(0, 15));
      d = {$urandom()};
      if ($urandom_range(0, 9) < 4) g = rr_grant();
      else begin
        int r = $urandom_range(0, NC);
        g = (r == NC) ? '0 : 4'(1 << r);
      end
      applyStimulus(v, d, g);
    end
    guard = 0;
    while (!model_empty() && guard < 40) begin
      applyStimulus('0, '0, rr_grant());
      guard++;
    end
    check("drain_done", 32'(model_empty()), 32'h1);

    // 5. Multi-bit grant: no pop, sticky error
    applyStimulus(4'b0011, one_word(0, 8'h61) | one_word(1, 8'h62), '0);
    applyStimulus('0, '0, 4'b0011);
    check("t5_valid", 32'(out_valid_o), 32'h0);
    check("t5_err",   32'(err_o),       32'h1);
    check("t5_req",   32'(req_o),       32'h3);
    for (int i = 0; i < 3; i++) applyStimulus('0, '0, '0);
    check("t5_err_hold", 32'(err_o), 32'h1);

    // 6. Reset mid-stream discards buffered data immediately
    applyStimulus(4'b1111, {$urandom()}, '0);
    applyStimulus(4'b1111, {$urandom()}, '0);
    applyStimulus('0, '0, 4'b0001);
    check("t6_pre_valid", 32'(out_valid_o), 32'h1);
    reset = 1'b1;
    #1;
    check("t6_req",   32'(req_o),       32'h0);
    check("t6_valid", 32'(out_valid_o), 32'h0);
    check("t6_ready", 32'(in_ready_o),  32'hF);
    check("t6_err",   32'(err_o),       32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NC; k++) applyStimulus('0, '0, 4'(1 << k));
    check("t6_no_stale", 32'(out_data_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
